dtc_apb_arbiter: RTL

Two-requester APB master that shares the single APB configuration port of the DTC register-config decoder (dadd at 0x000, dsel at 0x100). Each requester uses a simple req/ack command interface. The block arbitrates round-robin between them and sequences compliant APB SETUP/ACCESS phases. It also terminates hung transfers with a timeout error. It sits between the host-side/sequencer-side command sources and the decoder's psel/paddr/penable/pwrite/pwdata/pready/prdata inputs.

---
 rtl/dtc_apb_pkg.sv | 17 +
 rtl/dtc_rr_arb2.sv | 28 ++
 rtl/dtc_apb_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dtc_apb_pkg.sv
// Shared types and constants for the DTC APB configuration-port arbiter.
package dtc_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Register-config decoder windows behind the shared APB port
    localparam logic [31:0] DTC_DADD_ADDR = 32'h0000_0000;
    localparam logic [31:0] DTC_DSEL_ADDR = 32'h0000_0100;

    localparam int DTC_TIMEOUT_DEF = 255;
    localparam int TO_CNT_W        = 8;

endpackage

// File: rtl/dtc_rr_arb2.sv
// Two-way round-robin arbiter; last_grant resets to 1 so requester 0 wins
// the first contention.
module dtc_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (en_i && (|gnt_o)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/dtc_apb_arbiter.sv
// Two-requester APB master for the DTC register-config port: round-robin
// grant, SETUP/ACCESS sequencing and timeout termination of hung transfers.
module dtc_apb_arbiter
    import dtc_apb_pkg::*;
#(
    parameter int APB_AWIDTH  = 32,
    parameter int APB_DWIDTH  = 32,
    parameter int TIMEOUT_CYC = DTC_TIMEOUT_DEF
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  m0_req,
    input  logic [APB_AWIDTH-1:0] m0_addr,
    input  logic                  m0_write,
    input  logic [APB_DWIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [APB_DWIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic [APB_AWIDTH-1:0] m1_addr,
    input  logic                  m1_write,
    input  logic [APB_DWIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [APB_DWIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  psel,
    output logic [APB_AWIDTH-1:0] paddr,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_DWIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [APB_DWIDTH-1:0] prdata
);

    // Counter holds completed ACCESS cycles, so the last allowed one sees TIMEOUT_CYC-1
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

    apb_state_e                       state_q, state_d;
    logic                             sel_q, sel_d;
    logic                             psel_q, psel_d;
    logic                             penable_q, penable_d;
    logic                             pwrite_q, pwrite_d;
    logic [APB_AWIDTH-1:0]            paddr_q, paddr_d;
    logic [APB_DWIDTH-1:0]            pwdata_q, pwdata_d;
    logic [1:0]                       ack_q, ack_d;
    logic [1:0]                       err_q, err_d;
    logic [1:0][APB_DWIDTH-1:0]       rdata_q, rdata_d;
    logic [TO_CNT_W-1:0]              cnt_q, cnt_d;

    logic [1:0]                       req, elig, gnt, wr_in;
    logic [1:0][APB_AWIDTH-1:0]       addr_in;
    logic [1:0][APB_DWIDTH-1:0]       wdata_in;

    assign req      = {m1_req, m0_req};
    assign wr_in    = {m1_write, m0_write};
    assign addr_in  = {m1_addr, m0_addr};
    assign wdata_in = {m1_wdata, m0_wdata};

    // A requester being acked this cycle still has req high; keep it out
    assign elig = req & ~ack_q;

    dtc_rr_arb2 u_arb (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .req_i  (elig),
        .en_i   (state_q == IDLE),
        .gnt_o  (gnt)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        ack_d     = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    sel_d    = gnt[1];
                    psel_d   = 1'b1;
                    paddr_d  = addr_in[gnt[1]];
                    pwrite_d = wr_in[gnt[1]];
                    pwdata_d = wr_in[gnt[1]] ? wdata_in[gnt[1]] : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // pready on the timeout cycle wins: it is a normal completion
                if (pready || (cnt_q == TO_LAST)) begin
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                    pwrite_d       = 1'b0;
                    paddr_d        = '0;
                    pwdata_d       = '0;
                    cnt_d          = '0;
                    ack_d[sel_q]   = 1'b1;
                    err_d[sel_q]   = !pready;
                    rdata_d[sel_q] = (pready && !pwrite_q) ? prdata : '0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign psel     = psel_q;
    assign penable  = penable_q;
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];

endmodule
